// File: rtl/pipelined_adder.sv
// pipelined_adder: add/subtract with the carry chain cut into STAGES ripple
// segments. Each stage adds one WIDTH/STAGES-bit slice and registers the
// carry. Operand slices travel with the operation so that every result
// leaves the last stage aligned. The pipeline advances as a single unit and
// freezes whenever the result at the output is not consumed.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int SEG = WIDTH / STAGES;

  // One pipeline slot. b already holds the effective addend (~B when
  // subtracting), and c holds the carry into the next slice to be added.
  // Slices of s above the current stage are still zero, and slices of a/b
  // below it are already consumed. a/b are kept whole so that the MSB
  // operand bits are still available to derive V at the output.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
  } stage_t;

  stage_t     src     [STAGES];
  stage_t     stg_d   [STAGES];
  stage_t     stg_q   [STAGES];
  logic [SEG:0] seg_sum [STAGES];
  logic       stall;

  // Per-stage slice addition, with the whole pipeline frozen on stall.
  always_comb begin
    stall      = stg_q[STAGES-1].vld & ~out_ready;
    // Subtraction is A + ~B + ~Cin, so invert B and the borrow on entry.
    src[0].vld = in_valid;
    src[0].a   = A;
    src[0].b   = sub ? ~B : B;
    src[0].s   = '0;
    src[0].c   = Cin ^ sub;
    for (int k = 1; k < STAGES; k++) src[k] = stg_q[k-1];
    for (int k = 0; k < STAGES; k++) begin
      seg_sum[k] = {1'b0, src[k].a[k*SEG +: SEG]}
                 + {1'b0, src[k].b[k*SEG +: SEG]}
                 + {{SEG{1'b0}}, src[k].c};
      stg_d[k] = src[k];
      stg_d[k].s[k*SEG +: SEG] = seg_sum[k][SEG-1:0];
      stg_d[k].c = seg_sum[k][SEG];
      if (stall) stg_d[k] = stg_q[k];
    end
  end

  // Stage registers; reset wins over any simultaneous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) stg_q[k] <= stg_d[k];
    end
  end

  // The carry into the MSB is recovered as a^b^s at that bit.
  assign out_valid = stg_q[STAGES-1].vld;
  assign S         = stg_q[STAGES-1].s;
  assign Cout      = stg_q[STAGES-1].c;
  assign V         = stg_q[STAGES-1].a[WIDTH-1] ^ stg_q[STAGES-1].b[WIDTH-1]
                   ^ stg_q[STAGES-1].s[WIDTH-1] ^ stg_q[STAGES-1].c;
  assign in_ready  = ~stall;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: four 32-bit adders (STAGES 1, 2, 4, 32) share one
// stimulus stream. Each has a slot model (latency STAGES, moves as a unit,
// freezes on stall), whose results come from signed/unsigned arithmetic.
module tb_pipelined_adder;

  localparam int W = 32;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0, sb = 1'b0;

  logic [W-1:0] ss [N];
  logic         ov [N], ir [N], co [N], vv [N];

  int stg [N] = '{1, 2, 4, 32};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .A(a), .B(b),
    .Cin(cin), .sub(sb), .out_valid(ov[0]), .out_ready(out_ready), .S(ss[0]),
    .Cout(co[0]), .V(vv[0]));
  pipelined_adder #(.WIDTH(W), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .A(a), .B(b),
    .Cin(cin), .sub(sb), .out_valid(ov[1]), .out_ready(out_ready), .S(ss[1]),
    .Cout(co[1]), .V(vv[1]));
  pipelined_adder #(.WIDTH(W), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .A(a), .B(b),
    .Cin(cin), .sub(sb), .out_valid(ov[2]), .out_ready(out_ready), .S(ss[2]),
    .Cout(co[2]), .V(vv[2]));
  pipelined_adder #(.WIDTH(W), .STAGES(32)) u_s32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .A(a), .B(b),
    .Cin(cin), .sub(sb), .out_valid(ov[3]), .out_ready(out_ready), .S(ss[3]),
    .Cout(co[3]), .V(vv[3]));

  // Golden result {V, Cout, S}: Cout/S from WIDTH+1-bit unsigned sums,
  // V from whether the true signed result fits in WIDTH bits.
  function automatic logic [W+1:0] gold(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic ci, input logic su);
    logic [W:0] u;
    longint     sv;
    logic       v;
    if (!su) begin
      u  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      sv = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    end else begin
      u  = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, ~ci};
      sv = longint'($signed(x)) - longint'($signed(y)) - longint'(ci);
    end
    v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    return {v, u};
  endfunction

  // Slot model per DUT: slot 0 is the newest entry, slot STAGES-1 the output.
  logic         mv [N][32];
  logic [W+1:0] mr [N][32];

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 32; j++) begin
        mv[i][j] = 1'b0;
        mr[i][j] = '0;
      end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        for (int j = 0; j < 32; j++) mv[i][j] = 1'b0;
      end else if (!(mv[i][stg[i]-1] && !out_ready)) begin
        for (int j = 31; j > 0; j--) begin
          mv[i][j] = mv[i][j-1];
          mr[i][j] = mr[i][j-1];
        end
        mv[i][0] = in_valid;
        mr[i][0] = gold(a, b, cin, sb);
      end
    end
  end

  // Per-cycle comparison of every DUT against its model.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic eo, er;
      eo = mv[i][stg[i]-1];
      er = !(eo && !out_ready);
      checks++;
      if (ov[i] !== eo || ir[i] !== er) begin
        errors++;
        $display("FAIL hs stages=%0d t=%0t out_valid=%b in_ready=%b want %b %b",
                 stg[i], $time, ov[i], ir[i], eo, er);
      end
      if (eo) begin
        checks++;
        if ({vv[i], co[i], ss[i]} !== mr[i][stg[i]-1]) begin
          errors++;
          $display("FAIL result stages=%0d t=%0t V/C/S=%b/%b/%h want %b/%b/%h",
                   stg[i], $time, vv[i], co[i], ss[i], mr[i][stg[i]-1][W+1],
                   mr[i][stg[i]-1][W], mr[i][stg[i]-1][W-1:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // Pins the model with a literal, then runs the op through the STAGES=4
  // DUT and checks both its latency and its literal result.
  task automatic directed(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic su, input logic [W-1:0] es,
                          input logic ec, input logic ev);
    int n;
    chk({nm, "_model"}, 64'(gold(x, y, ci, su)), 64'({ev, ec, es}));
    a = x; b = y; cin = ci; sb = su; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    do begin
      step();
      in_valid = 1'b0;
      n++;
    end while (!ov[2] && n < 20);
    chk({nm, "_latency"}, 64'(n), 64'd4);
    chk({nm, "_dut"}, 64'({vv[2], co[2], ss[2]}), 64'({ev, ec, es}));
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] r;
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = '1;
      2: r = 32'h8000_0000;
      3: r = 32'h7FFF_FFFF;
      default: r = $urandom;
    endcase
    return r;
  endfunction

  task automatic rnd_inputs();
    a = rnd_op(); b = rnd_op();
    cin = 1'($urandom_range(0, 1));
    sb  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int stalls, outs;
    // Reset state
    repeat (3) step();
    chk("reset_out_valid", 64'(ov[2]), 64'd0);
    chk("reset_S", 64'(ss[2]), 64'd0);
    rst = 1'b0;
    chk("ready_after_reset", 64'(ir[2]), 64'd1);

    directed("add_wrap", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    directed("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed("sub_borrow", 32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Back-to-back stream with out_ready low for two cycles mid-stream
    repeat (6) step();
    stalls = 0; outs = 0;
    for (int c = 0; c < 24; c++) begin
      in_valid  = (c < 10);
      rnd_inputs();
      out_ready = !(c == 6 || c == 7);
      #3;
      if (!ir[2]) stalls++;
      if (ov[2] && out_ready) outs++;
      step();
    end
    chk("stall_cycles", 64'(stalls), 64'd2);
    chk("stream_results", 64'(outs), 64'd8);

    // Reset with operations in flight, and an input offered during reset
    in_valid = 1'b1; out_ready = 1'b1; rnd_inputs(); step();
    rnd_inputs(); step();
    rst = 1'b1; rnd_inputs(); step();
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("flush_out_valid", 64'(ov[i]), 64'd0);
      chk("flush_S", 64'(ss[i]), 64'd0);
    end
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) chk("no_stale", 64'(ov[i]), 64'd0);
      step();
    end

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      rnd_inputs();
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
